// File: rtl/lockstep_voter_pkg.sv
// Shared types for the lockstep redundancy voter: FSM state encoding and replica limits.
package p_hardisc;

   localparam int VOTER_MAX_REPLICAS = 3;
   localparam int VOTER_STREAK_W     = 4;

   typedef enum logic [1:0] {
      OK        = 2'd0,
      TRANSIENT = 2'd1,
      DEGRADED  = 2'd2,
      FAILED    = 2'd3
   } voter_state_t;

endpackage

// File: rtl/lockstep_voter_if.sv
// Replica bundle bus between the replicated cores (master) and the voter (slave).
interface lockstep_voter_if #(
   parameter int REPLICAS = 3,
   parameter int WIDTH    = 96
);
   logic                           s_cmp_en_i;
   logic [REPLICAS-1:0][WIDTH-1:0] s_rep_bus_i;
   logic [WIDTH-1:0]               s_voted_bus_o;

   modport master (output s_cmp_en_i, s_rep_bus_i, input s_voted_bus_o);
   modport slave  (input s_cmp_en_i, s_rep_bus_i, output s_voted_bus_o);
endinterface

// File: rtl/lockstep_voter_tmr.sv
// Combinational bitwise 2-of-3 majority with a per-replica disagree flag.
module tmr_bit_voter #(
   parameter int WIDTH = 96
) (
   input  logic [WIDTH-1:0] rep0,
   input  logic [WIDTH-1:0] rep1,
   input  logic [WIDTH-1:0] rep2,
   output logic [WIDTH-1:0] voted,
   output logic [2:0]       disagree
);
   assign voted       = (rep0 & rep1) | (rep0 & rep2) | (rep1 & rep2);
   assign disagree[0] = |(rep0 ^ voted);
   assign disagree[1] = |(rep1 ^ voted);
   assign disagree[2] = |(rep2 ^ voted);
endmodule

// File: rtl/lockstep_voter.sv
// Lockstep redundancy voter: majority/compare of replica bundles with fault classification FSM.
// Optional macro PROTECTED_VOTER_DEGRADE_EN enables the DEGRADED (masked replica) path.
module lockstep_voter
   import p_hardisc::*;
#(
   parameter int REPLICAS = 3,
   parameter int WIDTH    = 96,
   parameter int PERSIST  = 4,
   parameter int CNT_W    = 8
) (
   input  logic                 s_clk_i,
   input  logic                 s_resetn_i,
   lockstep_voter_if.slave      bus,
   output logic                 s_mismatch_o,
   output logic [REPLICAS-1:0]  s_faulty_rep_o,
   output logic [CNT_W-1:0]     s_err_cnt_o,
   output voter_state_t         s_state_o,
   output logic                 s_unrec_err_o
);

   logic cmp_hit;

   if (REPLICAS == 3) begin : g_tmr
      logic [WIDTH-1:0]          maj, sel_lo, sel_hi;
      logic [2:0]                dis, faulty_q, masked_q;
      logic                      pair_diff, multi;
      logic [VOTER_STREAK_W-1:0] streak_q, streak_nx;
      voter_state_t              state_q;
      logic                      unrec_q;

      tmr_bit_voter #(.WIDTH(WIDTH)) u_tmr (
         .rep0     (bus.s_rep_bus_i[0]),
         .rep1     (bus.s_rep_bus_i[1]),
         .rep2     (bus.s_rep_bus_i[2]),
         .voted    (maj),
         .disagree (dis)
      );

      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      always_comb begin
         sel_lo = bus.s_rep_bus_i[0];
         sel_hi = bus.s_rep_bus_i[1];
         if (masked_q[0]) begin
            sel_lo = bus.s_rep_bus_i[1];
            sel_hi = bus.s_rep_bus_i[2];
         end else if (masked_q[1]) begin
            sel_hi = bus.s_rep_bus_i[2];
         end
      end

      // Once a replica is masked, the lowest healthy replica drives the bus, also in FAILED.
      assign bus.s_voted_bus_o = (masked_q != 3'b000) ? sel_lo : maj;
      assign pair_diff         = (sel_lo != sel_hi);
      assign multi             = |(dis & (dis - 3'd1));
      assign streak_nx         = streak_q + 1'b1;
      assign cmp_hit           = bus.s_cmp_en_i &&
                                 ((masked_q != 3'b000) ? pair_diff : (dis != 3'b000));

      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      always_ff @(posedge s_clk_i) begin
         if (!s_resetn_i) begin
            state_q  <= OK;
            faulty_q <= '0;
            masked_q <= '0;
            streak_q <= '0;
            unrec_q  <= 1'b0;
         end else if (bus.s_cmp_en_i) begin
            unique case (state_q)
               OK: begin
                  if (multi) begin
                     state_q  <= FAILED;
                     faulty_q <= dis;
                     unrec_q  <= 1'b1;
                  end else if (dis != 3'b000) begin
                     state_q  <= TRANSIENT;
                     faulty_q <= dis;
                     streak_q <= VOTER_STREAK_W'(1);
                  end
               end
               TRANSIENT: begin
                  if (multi) begin
                     state_q  <= FAILED;
                     faulty_q <= dis;
                     unrec_q  <= 1'b1;
                  end else if (dis == faulty_q) begin
                     streak_q <= streak_nx;
                     if (streak_nx == VOTER_STREAK_W'(PERSIST)) begin
`ifdef PROTECTED_VOTER_DEGRADE_EN
                        state_q  <= DEGRADED;
                        masked_q <= dis;
`else
                        state_q  <= FAILED;
                        unrec_q  <= 1'b1;
`endif
                     end
                  end else if (dis != 3'b000) begin
                     faulty_q <= dis;
                     streak_q <= VOTER_STREAK_W'(1);
                  end else begin
                     state_q  <= OK;
                     faulty_q <= '0;
                     streak_q <= '0;
                  end
               end
               DEGRADED: begin
                  if (pair_diff) begin
                     state_q <= FAILED;
                     unrec_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end

      assign s_faulty_rep_o = faulty_q;
      assign s_state_o      = state_q;
      assign s_unrec_err_o  = unrec_q;

   end else if (REPLICAS == 2) begin : g_dmr
      logic [1:0]   faulty_q;
      voter_state_t state_q;
      logic         unrec_q;

      assign bus.s_voted_bus_o = bus.s_rep_bus_i[0];
      assign cmp_hit = bus.s_cmp_en_i && (bus.s_rep_bus_i[0] != bus.s_rep_bus_i[1]);

      // Dual redundancy cannot tell which replica is wrong, so both are flagged.
      always_ff @(posedge s_clk_i) begin
         if (!s_resetn_i) begin
            state_q  <= OK;
            faulty_q <= '0;
            unrec_q  <= 1'b0;
         end else if (cmp_hit) begin
            state_q  <= FAILED;
            faulty_q <= 2'b11;
            unrec_q  <= 1'b1;
         end
      end

      assign s_faulty_rep_o = faulty_q;
      assign s_state_o      = state_q;
      assign s_unrec_err_o  = unrec_q;

   end else begin : g_single
      assign bus.s_voted_bus_o = bus.s_rep_bus_i[0];
      assign cmp_hit           = 1'b0;
      assign s_faulty_rep_o    = '0;
      assign s_state_o         = OK;
      assign s_unrec_err_o     = 1'b0;
   end

   always_ff @(posedge s_clk_i) begin
      if (!s_resetn_i) begin
         s_mismatch_o <= 1'b0;
         s_err_cnt_o  <= '0;
      end else begin
         s_mismatch_o <= cmp_hit;
         if (cmp_hit && (s_err_cnt_o != {CNT_W{1'b1}}))
            s_err_cnt_o <= s_err_cnt_o + 1'b1;
      end
   end

endmodule
